// File: rtl/pipe_ctrl_pkg.sv
// Shared defaults and the requester-id type for the issue controller.
package pipe_ctrl_pkg;

  localparam int LATENCY_DEF   = 2;
  localparam int DATA_W_DEF    = 27;
  localparam int RES_DEPTH_DEF = 4;
  localparam int STAT_W        = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/pipe_issue_ctrl_res_fifo.sv
// Result buffer: FIFO of {id, result} entries with wrapping pointers.
module res_fifo
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF + 1,
  parameter int DEPTH  = RES_DEPTH_DEF
) (
  input  logic              clk_pll,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Credit-based round-robin issue controller for a fixed-latency pipeline.
// Optional per-requester issue counters: define PIPE_ISSUE_CTRL_STATS_EN.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LATENCY   = LATENCY_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input  logic              clk_pll,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] pipe_in,
  input  logic [DATA_W-1:0] pipe_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  input  logic              res_ready
`ifdef PIPE_ISSUE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] issue_cnt0,
  output logic [STAT_W-1:0] issue_cnt1
`endif
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  logic [CNT_W-1:0]   outstanding;
  req_id_t            last_grant;
  logic               credit;
  logic               gnt0;
  logic               gnt1;
  logic               issue;
  logic               pop;
  logic               push;
  logic               full;
  logic               empty;
  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] id_p;
  logic [DATA_W:0]    head;

  // Issue stage: grant from registered credit and last_grant only.
  assign credit     = (outstanding < CNT_W'(RES_DEPTH));
  assign gnt0       = rst_n && credit && req0_valid && (!req1_valid || last_grant == REQ1);
  assign gnt1       = rst_n && credit && req1_valid && (!req0_valid || last_grant == REQ0);
  assign issue      = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    pipe_in = '0;
    if (gnt0)      pipe_in = req0_data;
    else if (gnt1) pipe_in = req1_data;
  end

  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      last_grant  <= REQ1;
      vld_p       <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (issue) last_grant <= gnt1 ? REQ1 : REQ0;
      vld_p[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // In-flight id tag travels with its valid; a cleared valid makes it don't-care.
  always_ff @(posedge clk_pll) begin
    id_p[0] <= gnt1;
    for (int i = 1; i < LATENCY; i++) id_p[i] <= id_p[i-1];
  end

  // Capture stage: result leaves the pipeline LATENCY cycles after issue.
  assign push = vld_p[LATENCY-1];
  assign pop  = res_valid && res_ready;

  res_fifo #(
    .DATA_W (DATA_W + 1),
    .DEPTH  (RES_DEPTH)
  ) u_res_fifo (
    .clk_pll (clk_pll),
    .rst_n   (rst_n),
    .push    (push),
    .din     ({id_p[LATENCY-1], pipe_out}),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  assign res_valid = !empty;
  assign res_data  = head[DATA_W-1:0];
  assign res_id    = head[DATA_W];

  always_ff @(posedge clk_pll) begin
    if (rst_n) assert (!(push && full));
  end

`ifdef PIPE_ISSUE_CTRL_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt0 <= '0;
      issue_cnt1 <= '0;
    end else begin
      if (gnt0) issue_cnt0 <= sat_inc(issue_cnt0);
      if (gnt1) issue_cnt1 <= sat_inc(issue_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl with a two-stage pipeline model (result = 3*x + 5).
module tb_pipe_issue_ctrl;

  localparam int DATA_W = 27;

  logic              clk_pll = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] pipe_in, pipe_out;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_id;
  logic              res_ready;
`ifdef PIPE_ISSUE_CTRL_STATS_EN
  logic [15:0]       issue_cnt0, issue_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;
  int g0cnt, g1cnt;
  logic [DATA_W:0]   sb[$];
  logic [DATA_W-1:0] s1, s2;

  always #5 clk_pll = ~clk_pll;

  pipe_issue_ctrl #(.LATENCY(2), .DATA_W(DATA_W), .RES_DEPTH(4)) dut (
    .clk_pll    (clk_pll),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .pipe_in    (pipe_in),
    .pipe_out   (pipe_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
`ifdef PIPE_ISSUE_CTRL_STATS_EN
    ,
    .issue_cnt0 (issue_cnt0),
    .issue_cnt1 (issue_cnt1)
`endif
  );

  function automatic logic [DATA_W-1:0] f(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x * 27'd3 + 27'd5;
    return r;
  endfunction

  // Fixed two-cycle pipeline driven by the DUT; it is not reset.
  always_ff @(posedge clk_pll) begin
    s1 <= f(pipe_in);
    s2 <= s1;
  end
  assign pipe_out = s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle (inputs already set), then advances to the next negedge.
  task automatic step(input logic e0, input logic e1);
    logic [DATA_W-1:0] exp_in;
    logic [DATA_W:0]   hd;
    #1;
    exp_in = e0 ? req0_data : (e1 ? req1_data : '0);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    chk("pipe_in", {5'b0, pipe_in}, {5'b0, exp_in});
    g0cnt += int'(req0_ready);
    g1cnt += int'(req1_ready);
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("res_valid_extra", {31'b0, res_valid}, 32'd0);
      end else begin
        hd = sb.pop_front();
        chk("res_data", {5'b0, res_data}, {5'b0, hd[DATA_W-1:0]});
        chk("res_id", {31'b0, res_id}, {31'b0, hd[DATA_W]});
      end
    end
    if (e0)      sb.push_back({1'b0, f(req0_data)});
    else if (e1) sb.push_back({1'b1, f(req1_data)});
    @(negedge clk_pll);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk_pll);
    @(negedge clk_pll);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 27'h1;
    req1_data  = 27'h2;
    res_ready  = 1'b1;
    @(negedge clk_pll);
    @(negedge clk_pll);
    #1;
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    chk("rst_pipe_in", {5'b0, pipe_in}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", {5'b0, res_data}, 32'd0);
    chk("rst_res_id", {31'b0, res_id}, 32'd0);
    @(negedge clk_pll);

    // Single requester, first-result latency.
    rst_n      = 1'b1;
    req1_valid = 1'b0;
    req0_data  = 27'h0000123;
    step(1'b1, 1'b0);
    req0_valid = 1'b0;
    chk("lat_c1_res_valid", {31'b0, res_valid}, 32'd0);
    step(1'b0, 1'b0);
    chk("lat_c2_res_valid", {31'b0, res_valid}, 32'd0);
    step(1'b0, 1'b0);
    chk("lat_c3_res_valid", {31'b0, res_valid}, 32'd1);
    chk("lat_c3_res_data", {5'b0, res_data}, 32'h0000036E);
    chk("lat_c3_res_id", {31'b0, res_id}, 32'd0);
    step(1'b0, 1'b0);
    chk("lat_c4_res_valid", {31'b0, res_valid}, 32'd0);

    // Round-robin with both requesters valid.
    do_reset();
    g0cnt = 0;
    g1cnt = 0;
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_data = 27'h100 + 27'(i);
      req1_data = 27'h200 + 27'(i);
      step((i % 2) == 0, (i % 2) == 1);
    end
    chk("rr_cnt0", g0cnt, 32'd5);
    chk("rr_cnt1", g1cnt, 32'd5);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("rr_drain_valid", {31'b0, res_valid}, 32'd0);
    chk("rr_sb_left", sb.size(), 32'd0);

    // Credit exhaustion, one-cycle pop, then pop coinciding with capture.
    do_reset();
    res_ready  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req0_data = 27'h0A0000 + 27'(c);
      req1_data = 27'h0B0000 + 27'(c);
      step(c < 4 && (c % 2) == 0, c < 4 && (c % 2) == 1);
    end
    chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
    chk("stall_head_data", {5'b0, res_data}, 32'h001E0005);
    chk("stall_head_id", {31'b0, res_id}, 32'd0);
    res_ready = 1'b1;
    req0_data = 27'h0A0008;
    req1_data = 27'h0B0008;
    step(1'b0, 1'b0);
    res_ready = 1'b0;
    req0_data = 27'h0A0009;
    req1_data = 27'h0B0009;
    step(1'b1, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(1'b0, 1'b0);
    res_ready = 1'b1;
    for (int c = 11; c < 15; c++) step(1'b0, 1'b0);
    chk("full_drain_valid", {31'b0, res_valid}, 32'd0);
    chk("full_sb_left", sb.size(), 32'd0);

    // Reset with work in flight and results buffered.
    do_reset();
    res_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req0_data = 27'h0C0000 + 27'(c);
      step(1'b1, 1'b0);
    end
    req0_valid = 1'b0;
    chk("pre_rst_res_valid", {31'b0, res_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_rst_res_data", {5'b0, res_data}, 32'd0);
    chk("mid_rst_pipe_in", {5'b0, pipe_in}, 32'd0);
    @(negedge clk_pll);
    rst_n = 1'b1;
    sb.delete();
    res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_res_valid", {31'b0, res_valid}, 32'd0);
      step(1'b0, 1'b0);
    end

`ifdef PIPE_ISSUE_CTRL_STATS_EN
    do_reset();
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("stats_rst_cnt0", {16'b0, issue_cnt0}, 32'd0);
    for (int c = 0; c < 70000; c++) @(negedge clk_pll);
    req0_valid = 1'b0;
    @(negedge clk_pll);
    chk("stats_sat_cnt0", {16'b0, issue_cnt0}, 32'h0000FFFF);
    chk("stats_cnt1", {16'b0, issue_cnt1}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
